sysid_regbank: RTL and testbench

Parametrised system identification register bank on the Avalon-MM fabric; successor to the two-word sysid slave. It provides:

- the fixed system ID and build timestamp;
- a free-running 64-bit uptime counter with tear-free snapshot reads;
- a writable scratch register, a capability word and `NUM_USER` externally supplied read-only words.

Software uses it for image identification, bus sanity checks and coarse time measurement.

---
 rtl/sysid_regbank_pkg.sv | 29 ++
 rtl/sysid_regbank_if.sv | 30 +++
 rtl/sysid_regbank_uptime_counter.sv | 40 ++++
 rtl/sysid_regbank.sv | 97 +++++++++
 tb/tb_sysid_regbank.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sysid_regbank_pkg.sv
// sysid_regbank_pkg
// Shared definitions for the system identification register bank:
//   - word_t         : 32-bit bus data word
//   - OFF_*          : register word offsets
//   - CAP_UPTIME_BIT : CAP bit that reports whether the uptime counter is built
//   - cap_word()     : builds the CAP register value
package sysid_regbank_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned OFF_ID      = 0;
  localparam int unsigned OFF_TS      = 1;
  localparam int unsigned OFF_UP_LO   = 2;
  localparam int unsigned OFF_UP_HI   = 3;
  localparam int unsigned OFF_SCRATCH = 4;
  localparam int unsigned OFF_CAP     = 5;
  localparam int unsigned OFF_USER0   = 6;

  localparam int unsigned CAP_UPTIME_BIT = 8;

  function automatic word_t cap_word(input int unsigned num_user, input logic uptime_en);
    word_t w;
    w                 = '0;
    w[7:0]            = num_user[7:0];
    w[CAP_UPTIME_BIT] = uptime_en;
    return w;
  endfunction

endpackage

// File: rtl/sysid_regbank_if.sv
// sysid_regbank_if
// Avalon-MM slave bus of the register bank (no waitrequest).
//   address       : word address, ADDR_W bits
//   read / write  : access strobes
//   writedata     : write data
//   readdata      : read data, valid when readdatavalid=1
//   readdatavalid : one-cycle read response pulse
// Modports: master (bus initiator), slave (register bank).
interface sysid_regbank_if
  import sysid_regbank_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  word_t             writedata;
  word_t             readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regbank_uptime_counter.sv
// sysid_uptime_counter
// Free-running 64-bit uptime counter with a high-word snapshot register.
// The snapshot captures the high word in the same cycle the low word is read,
// so a following UP_HI read is consistent with the UP_LO value.
// Ports:
//   clock, reset : clock, async active-high reset
//   snap_i       : latch counter[63:32] into the snapshot at this edge
//   count_lo_o   : live counter[31:0]
//   snap_hi_o    : snapshot register
module sysid_uptime_counter
  import sysid_regbank_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  snap_i,
  output word_t count_lo_o,
  output word_t snap_hi_o
);

  logic [63:0] cnt_q, cnt_d;
  word_t       snap_q, snap_d;

  // Natural 64-bit wrap from all-ones back to zero.
  assign cnt_d  = cnt_q + 64'd1;
  assign snap_d = snap_i ? cnt_q[63:32] : snap_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign count_lo_o = cnt_q[31:0];
  assign snap_hi_o  = snap_q;

endmodule

// File: rtl/sysid_regbank.sv
// sysid_regbank
// System identification register bank on Avalon-MM: fixed ID and build
// timestamp, optional 64-bit uptime counter with tear-free snapshot, a
// scratch register, a capability word and NUM_USER external read-only words.
// Build option: define SYSID_UPTIME_EN to include the uptime counter;
// otherwise UP_LO/UP_HI read 0 and CAP bit 8 is 0.
// Ports:
//   clock, reset : clock, async active-high reset
//   bus          : Avalon-MM slave (sysid_regbank_if.slave)
//   user_words   : user word k at bits [32k+31:32k]
module sysid_regbank
  import sysid_regbank_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'd1491003564,
  parameter int unsigned NUM_USER  = 2,
  parameter int unsigned ADDR_W    = 4,
  localparam int unsigned UW_W     = 32 * ((NUM_USER > 0) ? NUM_USER : 1)
) (
  input  logic            clock,
  input  logic            reset,
  sysid_regbank_if.slave  bus,
  input  logic [UW_W-1:0] user_words
);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       addr_w;
  word_t             up_lo, up_hi;
  word_t             mux_data;
  word_t             rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  word_t             scratch_q, scratch_d;

  assign addr   = bus.address;
  assign addr_w = 32'(addr);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_EN = 1'b1;
  logic snap;

  // The UP_LO read itself latches the high word, keeping the pair tear-free.
  assign snap = bus.read && (addr_w == OFF_UP_LO);

  sysid_uptime_counter u_uptime (
    .clock      (clock),
    .reset      (reset),
    .snap_i     (snap),
    .count_lo_o (up_lo),
    .snap_hi_o  (up_hi)
  );
`else
  localparam logic UPTIME_EN = 1'b0;
  assign up_lo = '0;
  assign up_hi = '0;
`endif

  always_comb begin
    mux_data = '0;
    case (addr_w)
      OFF_ID:      mux_data = SYSTEM_ID;
      OFF_TS:      mux_data = TIMESTAMP;
      OFF_UP_LO:   mux_data = up_lo;
      OFF_UP_HI:   mux_data = up_hi;
      OFF_SCRATCH: mux_data = scratch_q;
      OFF_CAP:     mux_data = cap_word(NUM_USER, UPTIME_EN);
      default: begin
        for (int k = 0; k < int'(NUM_USER); k++) begin
          if (addr_w == OFF_USER0 + 32'(k)) mux_data = user_words[32*k +: 32];
        end
      end
    endcase
  end

  always_comb begin
    rvalid_d  = bus.read;
    rdata_d   = bus.read ? mux_data : rdata_q;
    scratch_d = scratch_q;
    // A simultaneous read wins; the write is dropped.
    if (bus.write && !bus.read && (addr_w == OFF_SCRATCH)) scratch_d = bus.writedata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      scratch_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      scratch_q <= scratch_d;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regbank.sv
// tb_sysid_regbank
// Self-checking bench for sysid_regbank: directed scenarios plus randomized
// traffic compared against a register-map reference model.
// Honours SYSID_UPTIME_EN the same way the design does.
module tb_sysid_regbank;
  import sysid_regbank_pkg::*;

  localparam int          NU  = 2;
  localparam int          AW  = 4;
  localparam logic [31:0] SID = 32'h0000_0000;
  localparam logic [31:0] TS  = 32'd1491003564;
`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [32*NU-1:0] user_words = '0;

  sysid_regbank_if #(.ADDR_W(AW)) bus ();

  sysid_regbank #(
    .SYSTEM_ID (SID),
    .TIMESTAMP (TS),
    .NUM_USER  (NU),
    .ADDR_W    (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .user_words (user_words)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles elapsed since reset plus an offset (set when the
  // counter is forced) gives the live uptime value.
  logic [63:0] cyc;
  logic [63:0] m_off     = '0;
  logic [31:0] m_snap    = '0;
  logic [31:0] m_scratch = '0;
  logic [31:0] m_last    = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input int a, input logic [63:0] c);
    if (a == 0) return SID;
    if (a == 1) return TS;
    if (a == 2) return UP ? c[31:0] : 32'h0;
    if (a == 3) return UP ? m_snap : 32'h0;
    if (a == 4) return m_scratch;
    if (a == 5) return 32'(NU) + (UP ? 32'h100 : 32'h0);
    if (a >= 6 && a < 6 + NU) return user_words[32*(a-6) +: 32];
    return 32'h0;
  endfunction

  // One bus cycle: drive at negedge, check the response one edge later.
  task automatic cycle(input string tag, input bit rd, input bit wr,
                       input int a, input logic [31:0] wd);
    logic [31:0] exp;
    logic [63:0] c;
    @(negedge clock);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = AW'(a);
    bus.writedata = wd;
    c   = cyc + m_off;
    exp = ref_read(a, c);
    if (rd && a == 2 && UP) m_snap = c[63:32];
    if (wr && !rd && a == 4) m_scratch = wd;
    @(posedge clock);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    chk({tag, ".valid"}, 64'(bus.readdatavalid), 64'(rd));
    if (rd) m_last = exp;
    chk({tag, ".data"}, 64'(bus.readdata), 64'(m_last));
  endtask

  task automatic model_reset();
    m_off     = '0;
    m_snap    = '0;
    m_scratch = '0;
    m_last    = '0;
  endtask

  initial begin
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    model_reset();

    #12;
    chk("rst.valid", 64'(bus.readdatavalid), 64'd0);
    chk("rst.data",  64'(bus.readdata), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back identification reads.
    cycle("id",  1, 0, 0, '0);
    cycle("ts",  1, 0, 1, '0);
    cycle("cap", 1, 0, 5, '0);
    cycle("idle0", 0, 0, 0, '0);

    // Read/write collision: read wins, scratch unchanged.
    cycle("coll",      1, 1, 4, 32'h1);
    cycle("coll.after",1, 0, 4, '0);

    // Scratch write visible on the very next cycle; RO write ignored.
    cycle("scr.wr", 0, 1, 4, 32'hDEAD_BEEF);
    cycle("scr.rd", 1, 0, 4, '0);
    cycle("ro.wr",  0, 1, 0, 32'h1234);
    cycle("ro.rd",  1, 0, 0, '0);

    // User words and an unmapped offset.
    user_words = {32'hA5A5_0001, 32'h5A5A_0002};
    cycle("usr6",  1, 0, 6, '0);
    cycle("usr7",  1, 0, 7, '0);
    cycle("unm15", 1, 0, 15, '0);
    cycle("unm.wr", 0, 1, 9, 32'hFFFF_FFFF);

    // Uptime reads; snapshot stays consistent with the UP_LO value.
    cycle("uplo", 1, 0, 2, '0);
    cycle("uphi", 1, 0, 3, '0);

`ifdef SYSID_UPTIME_EN
    // Counter forced to 0x0000_0000_FFFF_FFFF in the UP_LO read cycle.
    @(negedge clock);
    force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
    m_off = 64'h0000_0000_FFFF_FFFF - cyc;
    bus.read    = 1'b1;
    bus.address = AW'(2);
    #4;
    release dut.u_uptime.cnt_q;
    m_snap = 32'h0;
    @(posedge clock);
    #1;
    bus.read = 1'b0;
    chk("wrap.lo.valid", 64'(bus.readdatavalid), 64'd1);
    chk("wrap.lo", 64'(bus.readdata), 64'h0000_0000_FFFF_FFFF);
    m_last = 32'hFFFF_FFFF;
    repeat (10) cycle("wrap.idle", 0, 0, 0, '0);
    cycle("wrap.hi", 1, 0, 3, '0);
    chk("wrap.hi.abs", 64'(bus.readdata), 64'd0);
    cycle("wrap.lo2", 1, 0, 2, '0);
    cycle("wrap.hi2", 1, 0, 3, '0);
    chk("wrap.hi2.abs", 64'(bus.readdata), 64'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      user_words = {$urandom, $urandom};
      cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), $urandom);
    end

    // Reset asserted in the cycle after a read is accepted.
    @(negedge clock);
    bus.read    = 1'b1;
    bus.address = AW'(1);
    @(posedge clock);
    #1;
    bus.read = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midrst.valid", 64'(bus.readdatavalid), 64'd0);
    chk("midrst.data",  64'(bus.readdata), 64'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("midrst.hold.valid", 64'(bus.readdatavalid), 64'd0);
    chk("midrst.hold.data",  64'(bus.readdata), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) cycle("postrst", 0, 0, 0, '0);
    cycle("postrst.scr", 1, 0, 4, '0);
    cycle("postrst.hi",  1, 0, 3, '0);
    cycle("postrst.lo",  1, 0, 2, '0);
    cycle("postrst.cap", 1, 0, 5, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
